arp_decode: RTL

// - Receive side of ARP: parses 28-byte ARP payload, arriving as MII nibbles after the Ethernet header.
// - Validates fixed header fields and filters on our IP/MAC.
// - Presents sender HA/PA and opcode through a valid/ready handshake to the ARP responder/cache.
// - Sits between the Ethernet RX parser (EtherType 0x0806) and the arp_encode reply path.

---
 rtl/arp_pkg.sv | 43 ++++
 rtl/arp_decode_if.sv | 23 ++
 rtl/arp_field_shift.sv | 36 +++
 rtl/arp_decode.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/arp_pkg.sv
// Shared ARP constants, field nibble offsets and the nibble ordering helper.
// The encode path uses the same helper so both directions agree on the MII nibble order.
package arp_pkg;

    localparam logic [15:0] ARP_HW_TYPE    = 16'h0001;
    localparam logic [15:0] ARP_PROT_TYPE  = 16'h0800;
    localparam logic [7:0]  ARP_HW_LEN     = 8'h06;
    localparam logic [7:0]  ARP_PROT_LEN   = 8'h04;
    localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
    localparam logic [15:0] ARP_OPER_REPLY = 16'h0002;

    localparam int HTYPE_OFF       = 0;
    localparam int PTYPE_OFF       = 4;
    localparam int HLEN_OFF        = 8;
    localparam int PLEN_OFF        = 10;
    localparam int OPER_OFF        = 12;
    localparam int SHA_OFF         = 16;
    localparam int SPA_OFF         = 28;
    localparam int THA_OFF         = 36;
    localparam int TPA_OFF         = 48;
    localparam int ARP_LEN_NIBBLES = 56;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_CHECK,
        ST_HOLD,
        ST_DONE,
        ST_DROP
    } arp_dec_state_t;

    // Nibble j of a width-bit field: bytes go MSB first, low nibble of each byte first.
    function automatic logic [47:0] arp_nib_insert(input logic [47:0] field, input int width,
                                                   input int j, input logic [3:0] nib);
        logic [47:0] r;
        int          lsb;
        lsb = width - 8 * (j / 2 + 1) + 4 * (j % 2);
        r = field;
        r[lsb +: 4] = nib;
        return r;
    endfunction

endpackage

// File: rtl/arp_decode_if.sv
// Nibble input stream plus decoded-request handshake of the ARP receive path.
// master = nibble source / request consumer, slave = arp_decode.
interface arp_decode_if;
    logic        en;
    logic        din_valid;
    logic [3:0]  din;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic        err;

    modport master (
        output en, din_valid, din, req_ready,
        input  req_valid, oper, sha, spa, err
    );

    modport slave (
        input  en, din_valid, din, req_ready,
        output req_valid, oper, sha, spa, err
    );
endinterface

// File: rtl/arp_field_shift.sv
// Deserialises one ARP field from the nibble stream: captures the nibbles whose
// index falls inside [OFF, OFF + WIDTH/4) into their byte/nibble slot.
module arp_field_shift
    import arp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OFF   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [5:0]       idx_i,
    input  logic [3:0]       nib_i,
    output logic [WIDTH-1:0] field_o
);
    logic [WIDTH-1:0] field_q, field_d;
    logic             hit;

    always_comb begin
        hit     = (int'(idx_i) >= OFF) && (int'(idx_i) < OFF + WIDTH / 4);
        field_d = field_q;
        if (load_i && hit) begin
            field_d = WIDTH'(arp_nib_insert(48'(field_q), WIDTH, int'(idx_i) - OFF, nib_i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            field_q <= '0;
        end else begin
            field_q <= field_d;
        end
    end

    assign field_o = field_q;
endmodule

// File: rtl/arp_decode.sv
// ARP receive decoder: parses the 28-byte payload from MII nibbles, validates it and
// presents sender HA/PA plus opcode through a registered valid/ready handshake.
module arp_decode
    import arp_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h0,
    parameter logic [31:0] IP_ADDR  = 32'h0
) (
    input logic         clk,
    input logic         rst,
    arp_decode_if.slave bus
);
    localparam logic [5:0] LAST_K = 6'(ARP_LEN_NIBBLES - 1);

    arp_dec_state_t state_q, state_d;
    logic           en_q, dv_q, ign_q;
    logic [3:0]     din_q;
    logic [5:0]     k_q, k_d;
    logic           req_valid_q, req_valid_d;
    logic           err_q, err_d;
    logic [15:0]    oper_q, oper_d;
    logic [47:0]    sha_q, sha_d;
    logic [31:0]    spa_q, spa_d;
    logic           load, frame_ok, pending;

    logic [15:0]    htype_f, ptype_f, oper_f;
    logic [7:0]     hlen_f, plen_f;
    logic [47:0]    sha_f, tha_f;
    logic [31:0]    spa_f, tpa_f;

    // Shadow buffer: every field is captured here while the frame streams in.
    assign load = en_q && dv_q && ((state_q == ST_IDLE && !ign_q) || state_q == ST_RECV);

    arp_field_shift #(.WIDTH(16), .OFF(HTYPE_OFF)) u_htype (.clk(clk), .rst(rst),
        .load_i(load), .idx_i(k_q), .nib_i(din_q), .field_o(htype_f));
    arp_field_shift #(.WIDTH(16), .OFF(PTYPE_OFF)) u_ptype (.clk(clk), .rst(rst),
        .load_i(load), .idx_i(k_q), .nib_i(din_q), .field_o(ptype_f));
    arp_field_shift #(.WIDTH(8),  .OFF(HLEN_OFF))  u_hlen  (.clk(clk), .rst(rst),
        .load_i(load), .idx_i(k_q), .nib_i(din_q), .field_o(hlen_f));
    arp_field_shift #(.WIDTH(8),  .OFF(PLEN_OFF))  u_plen  (.clk(clk), .rst(rst),
        .load_i(load), .idx_i(k_q), .nib_i(din_q), .field_o(plen_f));
    arp_field_shift #(.WIDTH(16), .OFF(OPER_OFF))  u_oper  (.clk(clk), .rst(rst),
        .load_i(load), .idx_i(k_q), .nib_i(din_q), .field_o(oper_f));
    arp_field_shift #(.WIDTH(48), .OFF(SHA_OFF))   u_sha   (.clk(clk), .rst(rst),
        .load_i(load), .idx_i(k_q), .nib_i(din_q), .field_o(sha_f));
    arp_field_shift #(.WIDTH(32), .OFF(SPA_OFF))   u_spa   (.clk(clk), .rst(rst),
        .load_i(load), .idx_i(k_q), .nib_i(din_q), .field_o(spa_f));
    arp_field_shift #(.WIDTH(48), .OFF(THA_OFF))   u_tha   (.clk(clk), .rst(rst),
        .load_i(load), .idx_i(k_q), .nib_i(din_q), .field_o(tha_f));
    arp_field_shift #(.WIDTH(32), .OFF(TPA_OFF))   u_tpa   (.clk(clk), .rst(rst),
        .load_i(load), .idx_i(k_q), .nib_i(din_q), .field_o(tpa_f));

    assign frame_ok = (htype_f == ARP_HW_TYPE) && (ptype_f == ARP_PROT_TYPE) &&
                      (hlen_f == ARP_HW_LEN) && (plen_f == ARP_PROT_LEN) &&
                      (tpa_f == IP_ADDR) &&
                      ((oper_f == ARP_OPER_REQ) ||
                       (oper_f == ARP_OPER_REPLY && tha_f == MAC_ADDR));

    // A previous request still waiting for its consumer makes the new frame an overflow.
    assign pending = req_valid_q && !bus.req_ready;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        err_d       = 1'b0;
        req_valid_d = req_valid_q;
        oper_d      = oper_q;
        sha_d       = sha_q;
        spa_d       = spa_q;
        if (req_valid_q && bus.req_ready) begin
            req_valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                k_d = '0;
                if (en_q && dv_q && !ign_q) begin
                    k_d     = 6'd1;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                if (!en_q) begin
                    state_d = ST_DROP;
                    err_d   = 1'b1;
                end else if (dv_q) begin
                    if (k_q == LAST_K) begin
                        state_d = ST_CHECK;
                    end else begin
                        k_d = k_q + 6'd1;
                    end
                end
            end
            ST_CHECK: begin
                k_d = '0;
                if (frame_ok && !pending) begin
                    state_d     = ST_HOLD;
                    req_valid_d = 1'b1;
                    oper_d      = oper_f;
                    sha_d       = sha_f;
                    spa_d       = spa_f;
                end else begin
                    state_d = ST_DROP;
                    err_d   = 1'b1;
                end
            end
            // The held request lives in req_valid_q, so the receiver may rearm once en falls.
            ST_HOLD: begin
                if (req_valid_q && bus.req_ready) begin
                    state_d = ST_DONE;
                end else if (!en_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE, ST_DROP: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stream inputs are registered once; ign_q blocks the tail of a frame cut by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            dv_q        <= 1'b0;
            din_q       <= '0;
            ign_q       <= 1'b1;
            state_q     <= ST_IDLE;
            k_q         <= '0;
            req_valid_q <= 1'b0;
            err_q       <= 1'b0;
            oper_q      <= '0;
            sha_q       <= '0;
            spa_q       <= '0;
        end else begin
            en_q        <= bus.en;
            dv_q        <= bus.din_valid;
            din_q       <= bus.din;
            if (!bus.en) begin
                ign_q <= 1'b0;
            end
            state_q     <= state_d;
            k_q         <= k_d;
            req_valid_q <= req_valid_d;
            err_q       <= err_d;
            oper_q      <= oper_d;
            sha_q       <= sha_d;
            spa_q       <= spa_d;
        end
    end

    assign bus.req_valid = req_valid_q;
    assign bus.err       = err_q;
    assign bus.oper      = oper_q;
    assign bus.sha       = sha_q;
    assign bus.spa       = spa_q;
endmodule
